pc_redirect_ctrl: RTL and testbench

Next-PC sequencer for the fetch stage of the dynamic pipeline. It owns the fetch PC register and arbitrates redirect requests from decode (J/JAL, conditional branch), execute (JR/JALR), and the exception unit (trap, ERET). It applies MIPS delay-slot semantics and holds a resolved target across fetch stalls until it can be applied.

---
 rtl/pc_redirect_pkg.sv | 22 ++
 rtl/pc_target_calc.sv | 23 ++
 rtl/pc_redirect_ctrl.sv | 149 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
// Shared types and defaults for the fetch-PC redirect sequencer.
package pc_redirect_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    TRAP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_BR   = 3'd1,
    SRC_J    = 3'd2,
    SRC_JR   = 3'd3,
    SRC_ERET = 3'd4,
    SRC_EXC  = 3'd5
  } src_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0040_0004;

endpackage

// File: rtl/pc_target_calc.sv
// Decode-stage target arithmetic: delay-slot PC, J-format target, branch target.
module pc_target_calc
  import pc_redirect_pkg::*;
(
  input  logic [31:0] id_pc,
  input  logic [25:0] jmp_imm,
  input  logic [15:0] br_off,
  output logic [31:0] slot_pc,
  output logic [31:0] j_tgt,
  output logic [31:0] br_tgt
);

  logic [31:0] br_disp;

  always_comb begin
    slot_pc = id_pc + 32'd4;
    j_tgt   = {slot_pc[31:28], jmp_imm, 2'b00};
    br_disp = {{14{br_off[15]}}, br_off, 2'b00};
    // Wraps modulo 2^32 by construction.
    br_tgt  = slot_pc + br_disp;
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC owner: prioritises redirects, holds stalled targets, enters traps.
//
// state | meaning
// RUN   | normal fetch, PC advances or takes a redirect
// PEND  | redirect latched in pend_tgt, waiting for stall to drop
// TRAP  | exc/eret target just loaded, flush asserted this cycle
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] id_pc,
  input  logic        jmp_req,
  input  logic [25:0] jmp_imm,
  input  logic        br_req,
  input  logic        br_taken,
  input  logic [15:0] br_off,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_out,
  output logic        flush,
  output logic        slot_pending,
  output logic        misalign_err
);

  logic [31:0] slot_pc;
  logic [31:0] j_tgt;
  logic [31:0] br_tgt;

  pc_target_calc u_target_calc (
    .id_pc   (id_pc),
    .jmp_imm (jmp_imm),
    .br_off  (br_off),
    .slot_pc (slot_pc),
    .j_tgt   (j_tgt),
    .br_tgt  (br_tgt)
  );

  src_e        src;
  logic [31:0] req_tgt;
  logic        is_trap_src;
  logic        is_dec_src;

  always_comb begin
    src     = SRC_NONE;
    req_tgt = '0;
    if (exc_req) begin
      src     = SRC_EXC;
      req_tgt = EXC_VECTOR;
    end else if (eret_req) begin
      src     = SRC_ERET;
      req_tgt = epc;
    end else if (jr_req) begin
      src     = SRC_JR;
      req_tgt = jr_target;
    end else if (jmp_req) begin
      src     = SRC_J;
      req_tgt = j_tgt;
    end else if (br_req && br_taken) begin
      src     = SRC_BR;
      req_tgt = br_tgt;
    end
    is_trap_src = (src == SRC_EXC) || (src == SRC_ERET);
    is_dec_src  = (src == SRC_BR) || (src == SRC_J) || (src == SRC_JR);
  end

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        flush_q, flush_d;
  logic        slot_pending_q, slot_pending_d;
  logic        misalign_q, misalign_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    flush_d    = 1'b0;
    misalign_d = misalign_q;

    if (is_trap_src) begin
      // Traps bypass stall and discard any waiting redirect.
      pc_d       = req_tgt;
      pend_tgt_d = '0;
      state_d    = TRAP;
      flush_d    = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (is_dec_src) begin
            if (src == SRC_JR && jr_target[1:0] != 2'b00) misalign_d = 1'b1;
            if (stall) begin
              pend_tgt_d = req_tgt;
              state_d    = PEND;
            end else begin
              pc_d = req_tgt;
            end
          end else if (!stall) begin
            pc_d = pc_q + 32'd4;
          end
        end
        PEND: begin
          if (!stall) begin
            pc_d    = pend_tgt_q;
            state_d = RUN;
          end
        end
        TRAP: begin
          state_d = RUN;
          if (!stall) pc_d = pc_q + 32'd4;
        end
        default: state_d = RUN;
      endcase
    end

    slot_pending_d = (state_d == PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      pend_tgt_q     <= '0;
      flush_q        <= 1'b0;
      slot_pending_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_tgt_q     <= pend_tgt_d;
      flush_q        <= flush_d;
      slot_pending_q <= slot_pending_d;
      misalign_q     <= misalign_d;
    end
  end

  assign pc_out       = pc_q;
  assign flush        = flush_q;
  assign slot_pending = slot_pending_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with hand-computed expectations.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] id_pc;
  logic        jmp_req;
  logic [25:0] jmp_imm;
  logic        br_req;
  logic        br_taken;
  logic [15:0] br_off;
  logic        jr_req;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_out;
  logic        flush;
  logic        slot_pending;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  pc_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .id_pc        (id_pc),
    .jmp_req      (jmp_req),
    .jmp_imm      (jmp_imm),
    .br_req       (br_req),
    .br_taken     (br_taken),
    .br_off       (br_off),
    .jr_req       (jr_req),
    .jr_target    (jr_target),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .pc_out       (pc_out),
    .flush        (flush),
    .slot_pending (slot_pending),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic clear_reqs();
    jmp_req  = 1'b0;
    br_req   = 1'b0;
    br_taken = 1'b0;
    jr_req   = 1'b0;
    exc_req  = 1'b0;
    eret_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_reqs();
    stall     = 1'b0;
    id_pc     = '0;
    jmp_imm   = '0;
    br_off    = '0;
    jr_target = '0;
    epc       = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    do_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (pc_out !== 32'h0040_0000 || flush !== 1'b0 || slot_pending !== 1'b0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: pc=%h flush=%b slot=%b mis=%b expected pc=00400000 others 0",
               pc_out, flush, slot_pending, misalign_err);
    end
    tick();
    rst = 1'b0;
    exp_pc = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (pc_out !== exp_pc) begin
        errors++;
        $display("FAIL seq_advance[%0d]: pc=%h expected %h", i, pc_out, exp_pc);
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    id_pc   = 32'h8FFF_FFFC;
    jmp_imm = 26'h000_0010;
    jmp_req = 1'b1;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h9000_0040 || flush !== 1'b0) begin
      errors++;
      $display("FAIL jump_target: pc=%h flush=%b expected 90000040 flush=0", pc_out, flush);
    end
    tick();
    checks++;
    if (pc_out !== 32'h9000_0044) begin
      errors++;
      $display("FAIL jump_follow: pc=%h expected 90000044", pc_out);
    end
  endtask

  task automatic test_branch_stall();
    do_reset();
    id_pc    = 32'h0040_0010;
    br_off   = 16'hFFFE;
    br_req   = 1'b1;
    br_taken = 1'b1;
    stall    = 1'b1;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0040_0000 || slot_pending !== 1'b1) begin
      errors++;
      $display("FAIL br_stall_1: pc=%h slot=%b expected 00400000 slot=1", pc_out, slot_pending);
    end
    tick();
    checks++;
    if (pc_out !== 32'h0040_0000 || slot_pending !== 1'b1) begin
      errors++;
      $display("FAIL br_stall_2: pc=%h slot=%b expected 00400000 slot=1", pc_out, slot_pending);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc_out !== 32'h0040_000C || slot_pending !== 1'b0) begin
      errors++;
      $display("FAIL br_apply: pc=%h slot=%b expected 0040000c slot=0", pc_out, slot_pending);
    end
    tick();
    checks++;
    if (pc_out !== 32'h0040_0010) begin
      errors++;
      $display("FAIL br_follow: pc=%h expected 00400010", pc_out);
    end
  endtask

  task automatic test_branch_edges();
    do_reset();
    id_pc    = 32'h0000_1000;
    br_off   = 16'h0100;
    br_req   = 1'b1;
    br_taken = 1'b0;
    tick();
    checks++;
    if (pc_out !== 32'h0040_0004) begin
      errors++;
      $display("FAIL br_not_taken: pc=%h expected 00400004", pc_out);
    end
    id_pc    = 32'hFFFF_FFF8;
    br_off   = 16'h0001;
    br_taken = 1'b1;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0000_0000) begin
      errors++;
      $display("FAIL br_wrap: pc=%h expected 00000000", pc_out);
    end
  endtask

  task automatic test_exc_priority();
    do_reset();
    exc_req   = 1'b1;
    jr_req    = 1'b1;
    jr_target = 32'h0040_0123;
    jmp_req   = 1'b1;
    jmp_imm   = 26'h000_0100;
    stall     = 1'b1;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0040_0004 || flush !== 1'b1 || slot_pending !== 1'b0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL exc_entry: pc=%h flush=%b slot=%b mis=%b expected 00400004 1 0 0",
               pc_out, flush, slot_pending, misalign_err);
    end
    tick();
    checks++;
    if (pc_out !== 32'h0040_0004 || flush !== 1'b0) begin
      errors++;
      $display("FAIL exc_trap_hold: pc=%h flush=%b expected 00400004 flush=0", pc_out, flush);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc_out !== 32'h0040_0008) begin
      errors++;
      $display("FAIL exc_resume: pc=%h expected 00400008", pc_out);
    end
  endtask

  task automatic test_eret();
    do_reset();
    epc       = 32'h0040_1000;
    eret_req  = 1'b1;
    jr_req    = 1'b1;
    jr_target = 32'h0060_0000;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0040_1000 || flush !== 1'b1) begin
      errors++;
      $display("FAIL eret_entry: pc=%h flush=%b expected 00401000 flush=1", pc_out, flush);
    end
    exc_req = 1'b1;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0040_0004 || flush !== 1'b1) begin
      errors++;
      $display("FAIL trap_reenter: pc=%h flush=%b expected 00400004 flush=1", pc_out, flush);
    end
    id_pc   = 32'h0000_0000;
    jmp_imm = 26'h000_0200;
    jmp_req = 1'b1;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0040_0008 || flush !== 1'b0) begin
      errors++;
      $display("FAIL trap_ignores_jmp: pc=%h flush=%b expected 00400008 flush=0", pc_out, flush);
    end
  endtask

  task automatic test_pend();
    do_reset();
    jr_req    = 1'b1;
    jr_target = 32'h0050_0000;
    stall     = 1'b1;
    tick();
    clear_reqs();
    id_pc   = 32'h0000_0000;
    jmp_imm = 26'h000_0300;
    jmp_req = 1'b1;
    stall   = 1'b0;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0050_0000 || slot_pending !== 1'b0) begin
      errors++;
      $display("FAIL pend_ignores_jmp: pc=%h slot=%b expected 00500000 slot=0", pc_out, slot_pending);
    end
    jr_req    = 1'b1;
    jr_target = 32'h0070_0000;
    stall     = 1'b1;
    tick();
    clear_reqs();
    exc_req = 1'b1;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0040_0004 || flush !== 1'b1 || slot_pending !== 1'b0) begin
      errors++;
      $display("FAIL pend_exc: pc=%h flush=%b slot=%b expected 00400004 1 0", pc_out, flush, slot_pending);
    end
    stall = 1'b0;
    tick();
    tick();
    checks++;
    if (pc_out !== 32'h0040_000C) begin
      errors++;
      $display("FAIL pend_dropped: pc=%h expected 0040000c", pc_out);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    jr_req    = 1'b1;
    jr_target = 32'h0040_0102;
    tick();
    clear_reqs();
    checks++;
    if (pc_out !== 32'h0040_0102 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL jr_misalign: pc=%h mis=%b expected 00400102 mis=1", pc_out, misalign_err);
    end
    jr_req    = 1'b1;
    jr_target = 32'h0040_0200;
    tick();
    clear_reqs();
    exc_req = 1'b1;
    tick();
    clear_reqs();
    tick();
    checks++;
    if (pc_out !== 32'h0040_0008 || misalign_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign_sticky: pc=%h mis=%b expected 00400008 mis=1", pc_out, misalign_err);
    end
    do_reset();
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear: mis=%b expected 0", misalign_err);
    end
  endtask

  task automatic test_rst_mid_pend();
    do_reset();
    jr_req    = 1'b1;
    jr_target = 32'h0050_0000;
    stall     = 1'b1;
    tick();
    clear_reqs();
    rst = 1'b1;
    #1;
    checks++;
    if (pc_out !== 32'h0040_0000 || slot_pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: pc=%h slot=%b expected 00400000 slot=0", pc_out, slot_pending);
    end
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    tick();
    checks++;
    if (pc_out !== 32'h0040_0004 || slot_pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_target_lost: pc=%h slot=%b expected 00400004 slot=0", pc_out, slot_pending);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    stall = 1'b0;
    test_reset();
    test_jump();
    test_branch_stall();
    test_branch_edges();
    test_exc_priority();
    test_eret();
    test_pend();
    test_misalign();
    test_rst_mid_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
